servo_pwm_bank: RTL and testbench
=================================

Name: servo_pwm_bank

Overview:
- Consumer end of the coordinate bus. Takes the four 8-bit axis positions (x, y, z, gripper) and drives four hobby-servo PWM lines.
- Positions are sampled once per frame. Each channel's command slews toward its target by at most MAX_STEP per frame, which protects the arm from step jumps.
- Sits between the coordinate controller outputs and the FPGA servo pins.

Parameters:
- TICK_CYCLES, 391, clk cycles per PWM tick (391 at 100 MHz gives ~3.91 us, so 256 ticks ≈ 1 ms).
- BASE_TICKS, 256, ticks of high time at command 0 (1 ms).
- FRAME_TICKS, 5120, ticks per PWM frame (20 ms). Must exceed BASE_TICKS+255.
- MAX_STEP, 4, maximum change of a command per frame. 0 means no limit: cmd takes the target directly.
- RESET_POS, 128, value of every command after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- enable  in  1  run PWM generation; when low, outputs are idle
- pos_x  in  8  target position, x axis
- pos_y  in  8  target position, y axis
- pos_z  in  8  target position, z axis
- pos_g  in  8  target position, gripper
- pwm  out  4  servo lines: [0]=x, [1]=y, [2]=z, [3]=g
- frame_sync  out  1  one-cycle pulse at each frame start
- settled  out  1  high when all four commands equal their sampled targets

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, tick_cnt=0.
  - All cmd=RESET_POS; all sampled targets=RESET_POS.
  - pwm=0, frame_sync=0, settled=1.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 while enable=1.
  - tick_cnt increments on prescaler wrap and counts 0..FRAME_TICKS-1, then wraps to 0.
- Frame boundary: the clk edge on which prescaler wraps and tick_cnt wraps to 0. On that edge:
  - pos_x/y/z/g are latched into the target registers. Inputs are ignored at all other times.
  - Each cmd updates from the previously held target, per channel:
    - diff = target-cmd, computed signed 9-bit.
    - If MAX_STEP=0 or |diff|<=MAX_STEP: cmd=target.
    - Otherwise: cmd=cmd±MAX_STEP, toward the target.
    - cmd never wraps; it stays within 0..255 by construction.
  - Net effect: a new input takes effect one frame after it is latched.
  - frame_sync is registered high for exactly the following cycle.
- PWM output:
  - pwm[i] is registered: pwm[i] <= enable && (tick_cnt < BASE_TICKS + cmd_i), with the compare 10 bits wide.
  - Pulse high time = (BASE_TICKS+cmd_i)*TICK_CYCLES clk cycles, exact.
  - The pulse starts 1 cycle after the frame boundary.
  - cmd changes only at the frame boundary, so no pulse is ever truncated or glitched.
- settled: registered, = AND over channels of (cmd_i==target_i). It updates 1 cycle after cmd/target change.
- enable low:
  - prescaler and tick_cnt are held at 0; pwm=0; frame_sync=0.
  - cmd and targets are held.
- enable rising:
  - The first edge with enable=1 is treated as a frame boundary: latch, slew, then frame_sync.
  - A full frame follows.
- Simultaneous events: rst_n low overrides enable and the frame boundary.
- Reset mid-pulse: pwm drops to 0 on the next edge.
- Gripper: uses the same timing as the other axes; no special casing.

Test Plan:
- Params TICK_CYCLES=1, BASE_TICKS=10, FRAME_TICKS=300, MAX_STEP=0, with all pos=128 and enable=1 after reset:
  - -> frame_sync every 300 cycles.
  - -> each pwm high exactly 138 cycles per frame, rising 1 cycle after the boundary.
  - -> settled=1.
- Same params, pos_x=0, pos_g=255 before a boundary:
  - -> frame N+1: pwm[0] high 10 cycles, pwm[3] high 265 cycles.
  - -> settled low for 1 frame, then high.
- MAX_STEP=4, pos_y switched from 128 to 140:
  - -> cmd_y goes 128→132→136→140 over successive frames.
  - -> pwm[1] widths 138, 142, 146, 150 cycles.
  - -> settled=1 only after 140.
- MAX_STEP=4, pos_z switched from 2 to 0 and from 253 to 255:
  - -> cmd reaches exactly 0 and exactly 255 in one step.
  - -> no wrap.
- pos_x toggled mid-frame and restored before the boundary:
  - -> no change in pwm[0] width.
- enable dropped for 50 cycles mid-pulse, rst_n pulsed low mid-pulse:
  - -> pwm=0 next edge.
  - -> frame restarts immediately on re-enable with frame_sync.
  - -> after reset, all widths 138.

Source files
------------

// File: rtl/servo_pwm_bank.sv
// Four-channel hobby-servo PWM generator with per-frame slew limiting.
// Targets are latched at each frame start; commands step toward them by at most MAX_STEP per frame.
module servo_pwm_bank #(
    parameter int TICK_CYCLES = 391,
    parameter int BASE_TICKS  = 256,
    parameter int FRAME_TICKS = 5120,
    parameter int MAX_STEP    = 4,
    parameter int RESET_POS   = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] pos_x,
    input  logic [7:0] pos_y,
    input  logic [7:0] pos_z,
    input  logic [7:0] pos_g,
    output logic [3:0] pwm,
    output logic       frame_sync,
    output logic       settled
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int CW = (TW > 10) ? TW : 10;

    localparam logic [PW-1:0]       PRE_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0]       TICK_LAST = TW'(FRAME_TICKS - 1);
    localparam logic [9:0]          BASE10    = 10'(BASE_TICKS);
    localparam logic signed [8:0]   STEP9     = 9'(MAX_STEP);
    localparam logic [7:0]          STEP8     = 8'(MAX_STEP);
    localparam logic [7:0]          RST8      = 8'(RESET_POS);

    logic [PW-1:0]     prescaler;
    logic [TW-1:0]     tick_cnt;
    logic              en_d;
    logic              pre_wrap;
    logic              frame_start;
    logic [3:0][7:0]   pos_all;
    logic [3:0][7:0]   target;
    logic [3:0][7:0]   cmd;
    logic [3:0][9:0]   limit;
    logic              all_match;

    assign pos_all  = {pos_g, pos_z, pos_y, pos_x};
    assign pre_wrap = (prescaler == PRE_LAST);

    // A frame starts on the natural wrap or on the first enabled edge after idle/reset.
    assign frame_start = enable && ((pre_wrap && (tick_cnt == TICK_LAST)) || !en_d);

    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic signed [8:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if ((MAX_STEP == 0) || ((diff <= STEP9) && (diff >= -STEP9)))
            return tgt;
        else if (diff > 0)
            return cur + STEP8;
        else
            return cur - STEP8;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            tick_cnt  <= '0;
            en_d      <= 1'b0;
        end else begin
            en_d <= enable;
            if (!enable || frame_start) begin
                prescaler <= '0;
                tick_cnt  <= '0;
            end else if (pre_wrap) begin
                prescaler <= '0;
                tick_cnt  <= tick_cnt + TW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // NOTE: cmd and target are only 4x8 flops, so they get an explicit reset value rather than being left as memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cmd[i]    <= RST8;
                target[i] <= RST8;
            end
        end else if (frame_start) begin
            for (int i = 0; i < 4; i++) begin
                cmd[i]    <= slew(cmd[i], target[i]);
                target[i] <= pos_all[i];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        all_match = 1'b1;
        for (int i = 0; i < 4; i++) begin
            limit[i] = BASE10 + {2'b00, cmd[i]};
            if (cmd[i] != target[i])
                all_match = 1'b0;
        end
    end

    // pwm is held low on the frame-start edge so an enable-rise frame matches a wrapped one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm        <= '0;
            frame_sync <= 1'b0;
            settled    <= 1'b1;
        end else begin
            frame_sync <= frame_start;
            settled    <= all_match;
            for (int i = 0; i < 4; i++)
                pwm[i] <= enable && !frame_start && (CW'(tick_cnt) < CW'(limit[i]));
        end
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: one unlimited-slew and one MAX_STEP=4 instance share clock, reset and enable.
// Stimulus queues per-frame expected widths/settled; a monitor measures each completed frame and compares.
module tb_servo_pwm_bank;

    localparam int FRAME = 300;

    typedef struct packed {
        logic [7:0][8:0] w;
        logic            s0;
        logic            s4;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] px0, py0, pz0, pg0, px4, py4, pz4, pg4;
    logic [3:0] pwm0, pwm4;
    logic       fs0, fs4, st0, st4;

    int   total = 0;
    int   bad = 0;
    int   frames_done = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    servo_pwm_bank #(.TICK_CYCLES(1), .BASE_TICKS(10), .FRAME_TICKS(FRAME),
                     .MAX_STEP(0), .RESET_POS(128)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pos_x(px0), .pos_y(py0), .pos_z(pz0), .pos_g(pg0),
        .pwm(pwm0), .frame_sync(fs0), .settled(st0)
    );

    servo_pwm_bank #(.TICK_CYCLES(1), .BASE_TICKS(10), .FRAME_TICKS(FRAME),
                     .MAX_STEP(4), .RESET_POS(128)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pos_x(px4), .pos_y(py4), .pos_z(pz4), .pos_g(pg4),
        .pwm(pwm4), .frame_sync(fs4), .settled(st4)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sync(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (fs0 !== 1'b1 && n < 400);
        check({"sync_", tag}, int'(fs0 === 1'b1), 1);
    endtask

    task automatic set_pos(input logic [3:0][7:0] a, input logic [3:0][7:0] b);
        {pg0, pz0, py0, px0} = a;
        {pg4, pz4, py4, px4} = b;
    endtask

    // Positions presented for latching at frame boundary k ({g,z,y,x}).
    function automatic logic [3:0][7:0] p0_of(input int k);
        return (k >= 3 && k <= 5) ? {8'd255, 8'd128, 8'd128, 8'd0} : {4{8'd128}};
    endfunction

    function automatic logic [3:0][7:0] p4_of(input int k);
        if (k < 3)       return {4{8'd128}};
        else if (k <= 35) return {8'd253, 8'd2, 8'd128, 8'd128};
        else if (k <= 37) return {8'd255, 8'd0, 8'd128, 8'd128};
        else             return {8'd255, 8'd0, 8'd140, 8'd128};
    endfunction

    // Hand-derived commands in force during frame k.
    function automatic logic [3:0][7:0] c0_of(input int k);
        return (k >= 4 && k <= 6) ? {8'd255, 8'd128, 8'd128, 8'd0} : {4{8'd128}};
    endfunction

    function automatic logic [3:0][7:0] c4_of(input int k);
        logic [7:0] y, z, g;
        y = (k <= 38) ? 8'd128 : (k == 39) ? 8'd132 : (k == 40) ? 8'd136 : 8'd140;
        if (k <= 3) begin
            z = 8'd128; g = 8'd128;
        end else if (k <= 34) begin
            z = 8'(128 - 4 * (k - 3)); g = 8'(128 + 4 * (k - 3));
        end else if (k <= 36) begin
            z = 8'd2; g = 8'd253;
        end else begin
            z = 8'd0; g = 8'd255;
        end
        return {g, z, y, 8'd128};
    endfunction

    function automatic logic s0_of(input int k);
        return !(k == 3 || k == 6);
    endfunction

    function automatic logic s4_of(input int k);
        return (k <= 2) || (k == 35) || (k == 37) || (k >= 41);
    endfunction

    task automatic push_exp(input logic [3:0][7:0] c0, input logic [3:0][7:0] c4,
                            input logic s0, input logic s4);
        exp_t e;
        for (int ch = 0; ch < 4; ch++) begin
            e.w[ch]     = 9'(c0[ch]) + 9'd10;
            e.w[ch + 4] = 9'(c4[ch]) + 9'd10;
        end
        e.s0 = s0;
        e.s4 = s4;
        exp_q.push_back(e);
    endtask

    // Monitor: measures each frame between frame_sync pulses and scores it against the queue.
    initial begin
        int         cyc;
        bit         active;
        int         wid[8];
        int         rise[8];
        logic       sv0, sv4;
        logic [7:0] lines;
        exp_t       e;
        cyc = 0;
        active = 1'b0;
        sv0 = 1'b0;
        sv4 = 1'b0;
        forever begin
            @(negedge clk);
            lines = {pwm4, pwm0};
            if (rst_n !== 1'b1 || enable !== 1'b1) begin
                active = 1'b0;
            end else begin
                if (fs0 === 1'b1) begin
                    if (active) begin
                        check($sformatf("frame_period_f%0d", frames_done), cyc, FRAME);
                        check("sync_pair", int'(fs4 === 1'b1), 1);
                        check("queue_nonempty", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            for (int i = 0; i < 8; i++) begin
                                check($sformatf("width_d%0d_ch%0d_f%0d", (i < 4) ? 0 : 4, i % 4, frames_done),
                                      wid[i], int'(e.w[i]));
                                check($sformatf("rise_d%0d_ch%0d_f%0d", (i < 4) ? 0 : 4, i % 4, frames_done),
                                      rise[i], 1);
                            end
                            check($sformatf("settled_d0_f%0d", frames_done), int'(sv0), int'(e.s0));
                            check($sformatf("settled_d4_f%0d", frames_done), int'(sv4), int'(e.s4));
                            frames_done++;
                        end
                    end
                    active = 1'b1;
                    cyc = 0;
                    for (int i = 0; i < 8; i++) begin
                        wid[i] = 0;
                        rise[i] = -1;
                    end
                end
                if (active) begin
                    for (int i = 0; i < 8; i++) begin
                        if (lines[i] === 1'b1) begin
                            wid[i]++;
                            if (rise[i] < 0) rise[i] = cyc;
                        end
                    end
                    if (cyc == 2) begin
                        sv0 = st0;
                        sv4 = st4;
                    end
                    cyc++;
                    if (cyc > FRAME) begin
                        check("frame_period_overrun", cyc, FRAME);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        bit stayed_low;
        rst_n  = 1'b0;
        enable = 1'b0;
        set_pos(p0_of(0), p4_of(0));
        repeat (3) step();
        check("reset_pwm0", int'(pwm0), 0);
        check("reset_pwm4", int'(pwm4), 0);
        check("reset_sync", int'(fs0), 0);
        check("reset_settled0", int'(st0), 1);
        check("reset_settled4", int'(st4), 1);

        enable = 1'b1;
        step();
        rst_n = 1'b1;

        for (int k = 0; k < 42; k++) begin
            wait_sync($sformatf("f%0d", k));
            push_exp(c0_of(k), c4_of(k), s0_of(k), s4_of(k));
            repeat (50) step();
            if (k == 4) px0 = 8'd200;
            repeat (50) step();
            set_pos(p0_of(k + 1), p4_of(k + 1));
        end
        wait_sync("f42");

        // Drop enable mid-pulse for 50 cycles.
        repeat (20) step();
        check("pwm0_before_drop", int'(pwm0), 4'hF);
        check("pwm4_before_drop", int'(pwm4), 4'b1011);
        enable = 1'b0;
        step();
        check("pwm0_after_drop", int'(pwm0), 0);
        check("pwm4_after_drop", int'(pwm4), 0);
        check("sync_after_drop", int'(fs0), 0);
        stayed_low = 1'b1;
        for (int i = 0; i < 49; i++) begin
            step();
            if (pwm0 !== 4'h0 || pwm4 !== 4'h0 || fs0 !== 1'b0) stayed_low = 1'b0;
        end
        check("idle_while_disabled", int'(stayed_low), 1);

        enable = 1'b1;
        step();
        check("sync_on_reenable0", int'(fs0), 1);
        check("sync_on_reenable4", int'(fs4), 1);
        check("pwm0_at_reenable", int'(pwm0), 0);
        push_exp(c0_of(42), c4_of(42), s0_of(42), s4_of(42));
        step();
        check("pwm0_rise_after_reenable", int'(pwm0), 4'hF);
        wait_sync("reenable_end");

        // Reset pulse mid-pulse, with all positions returned to centre.
        repeat (30) step();
        check("pwm0_before_reset", int'(pwm0), 4'hF);
        rst_n = 1'b0;
        set_pos({4{8'd128}}, {4{8'd128}});
        step();
        check("pwm0_in_reset", int'(pwm0), 0);
        check("pwm4_in_reset", int'(pwm4), 0);
        check("sync_in_reset", int'(fs0), 0);
        check("settled4_in_reset", int'(st4), 1);
        repeat (3) step();
        push_exp({4{8'd128}}, {4{8'd128}}, 1'b1, 1'b1);
        rst_n = 1'b1;
        wait_sync("after_reset_start");
        wait_sync("after_reset_end");
        repeat (2) step();

        check("queue_drained", exp_q.size(), 0);
        check("frames_compared", frames_done, 44);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
